// File: rtl/nv_mem_reader.sv
// Burst reader for the non-volatile key/config memory: issues consecutive word reads and streams them out
// through a 2-entry buffer. Optional running XOR of accepted words when NV_MEM_RD_CHECKSUM_EN is defined.
module nv_mem_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_w,
  output logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready
`ifdef NV_MEM_RD_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] rd_checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_addr_last;
  logic [LEN_WIDTH-1:0]    r_issue_cnt;
  logic [LEN_WIDTH-1:0]    r_acc_cnt;
  logic                    r_inflight;
  logic [DATA_WIDTH-1:0]   r_buf [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;
  logic                    w_start;
  logic                    w_pop;
  logic                    w_issue;
  logic [2:0]              w_held;

  assign rd_valid = (r_count != 2'd0);
  assign rd_data  = r_buf[r_rd_ptr];
  assign w_pop    = rd_valid & rd_ready;
  assign w_start  = (r_state == S_IDLE) & start;

  // Words held after this cycle's pop; issuing keeps the total within the 2 buffer slots.
  assign w_held  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_READ) && (r_issue_cnt != '0) && (w_held < 3'd2);

  assign mem_addr_in = w_issue ? r_addr : r_addr_last;
  assign mem_w       = 1'b0;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DRAIN) && (r_acc_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (length == '0) ? S_DRAIN : S_READ;
      S_READ:  if (w_issue && (r_issue_cnt == LEN_ONE)) w_next = S_DRAIN;
      S_DRAIN: if (r_acc_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_addr_last <= '0;
      r_issue_cnt <= '0;
      r_acc_cnt   <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_start) begin
        r_addr      <= start_addr;
        r_issue_cnt <= length;
        r_acc_cnt   <= length;
      end else begin
        if (w_issue) begin
          r_addr      <= r_addr + ADDR_ONE;
          r_addr_last <= r_addr;
          r_issue_cnt <= r_issue_cnt - LEN_ONE;
        end
        if (w_pop) r_acc_cnt <= r_acc_cnt - LEN_ONE;
      end
    end
  end

  // Memory data lands one cycle after the address, so the in-flight flag doubles as the push strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_buf[r_wr_ptr] <= mem_data_out;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

`ifdef NV_MEM_RD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_checksum <= '0;
    else if (w_start) r_checksum <= '0;
    else if (w_pop)   r_checksum <= r_checksum ^ rd_data;
  end

  assign rd_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_nv_mem_reader.sv
// Directed self-checking bench for nv_mem_reader with a registered one-port memory model.
module tb_nv_mem_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = 8'h00;
  logic [8:0]  length = 9'd0;
  logic        rd_ready = 1'b0;
  logic        busy, done, mem_w, rd_valid;
  logic [7:0]  mem_addr_in;
  logic [31:0] mem_data_out;
  logic [31:0] rd_data;
`ifdef NV_MEM_RD_CHECKSUM_EN
  logic [31:0] rd_checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem [256];

  nv_mem_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LEN_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .mem_w(mem_w), .mem_addr_in(mem_addr_in),
    .mem_data_out(mem_data_out), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
`ifdef NV_MEM_RD_CHECKSUM_EN
    , .rd_checksum(rd_checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data_out <= mem[mem_addr_in];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next edge (E0); returns just after E0.
  task automatic issue_start(input logic [7:0] a, input logic [8:0] n);
    start_addr = a;
    length     = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_checks++; if (mem_w !== 1'b0) begin n_fail++; $display("FAIL reset_mem_w got %b want 0", mem_w); end
    n_checks++; if (mem_addr_in !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr got %h want 00", mem_addr_in); end
    n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
`ifdef NV_MEM_RD_CHECKSUM_EN
    n_checks++; if (rd_checksum !== 32'h0) begin n_fail++; $display("FAIL reset_checksum got %h want 0", rd_checksum); end
`endif
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic expv;
    rd_ready = 1'b1;
    issue_start(8'h10, 9'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      expv = (k >= 2) && (k <= 5);
      if (k == 0) begin
        n_checks++; if (mem_addr_in !== 8'h10) begin n_fail++; $display("FAIL basic_first_addr got %h want 10", mem_addr_in); end
      end
      n_checks++; if (rd_valid !== expv) begin n_fail++; $display("FAIL basic_valid k=%0d got %b want %b", k, rd_valid, expv); end
      if (expv) begin
        n_checks++;
        if (rd_data !== 32'hA5000010 + 32'(k - 2)) begin
          n_fail++; $display("FAIL basic_data k=%0d got %h want %h", k, rd_data, 32'hA5000010 + 32'(k - 2));
        end
      end
      n_checks++; if (done !== (k == 6)) begin n_fail++; $display("FAIL basic_done k=%0d got %b want %b", k, done, (k == 6)); end
      tick();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] ea;
    rd_ready = 1'b1;
    issue_start(8'hFE, 9'd4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 4) begin
        ea = 8'hFE + 8'(k);
        n_checks++; if (mem_addr_in !== ea) begin n_fail++; $display("FAIL wrap_addr k=%0d got %h want %h", k, mem_addr_in, ea); end
      end
      if ((k >= 2) && (k <= 5)) begin
        ea = 8'hFE + 8'(k - 2);
        n_checks++;
        if ((rd_valid !== 1'b1) || (rd_data !== {24'hA50000, ea})) begin
          n_fail++; $display("FAIL wrap_data k=%0d got v=%b %h want v=1 %h", k, rd_valid, rd_data, {24'hA50000, ea});
        end
      end
      n_checks++; if (done !== (k == 6)) begin n_fail++; $display("FAIL wrap_done k=%0d got %b want %b", k, done, (k == 6)); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  pat = 8'b01101001;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    int acc = 0;
    int ndone = 0;
    int ahead;
    rd_ready = 1'b1;
    issue_start(8'h30, 9'd5);
    for (int k = 0; k < 40; k++) begin
      rd_ready = pat[k % 8];
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if ((rd_valid !== 1'b1) || (rd_data !== prev_data)) begin
          n_fail++; $display("FAIL bp_stable k=%0d got v=%b %h want v=1 %h", k, rd_valid, rd_data, prev_data);
        end
      end
      if (busy === 1'b1) begin
        ahead = int'(8'(mem_addr_in - 8'h30)) - acc;
        n_checks++; if (ahead > 2) begin n_fail++; $display("FAIL bp_ahead k=%0d got %0d want <=2", k, ahead); end
      end
      if ((rd_valid === 1'b1) && (rd_ready === 1'b1)) begin
        n_checks++;
        if (rd_data !== 32'hA5000030 + 32'(acc)) begin
          n_fail++; $display("FAIL bp_data idx=%0d got %h want %h", acc, rd_data, 32'hA5000030 + 32'(acc));
        end
        acc++;
      end
      prev_stall = (rd_valid === 1'b1) && (rd_ready === 1'b0);
      prev_data  = rd_data;
      if (done === 1'b1) ndone++;
      tick();
    end
    n_checks++; if (acc != 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", acc); end
    n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL bp_done_count got %0d want 1", ndone); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end got %b want 0", busy); end
    rd_ready = 1'b1;
  endtask

  task automatic test_zero_len_and_ignore();
    int cnt = 0;
    int ndone = 0;
    rd_ready = 1'b1;
    issue_start(8'h00, 9'd0);
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid got %b want 0", rd_valid); end
    tick();
    @(negedge clk);
    n_checks++; if ((done !== 1'b0) || (busy !== 1'b0) || (rd_valid !== 1'b0)) begin
      n_fail++; $display("FAIL zero_after got done=%b busy=%b v=%b want 0 0 0", done, busy, rd_valid);
    end
    tick();
    issue_start(8'h20, 9'd3);
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin start = 1'b1; start_addr = 8'h80; length = 9'd7; end
      if (k == 2) start = 1'b0;
      @(negedge clk);
      if ((rd_valid === 1'b1) && (rd_ready === 1'b1)) begin
        n_checks++;
        if (rd_data !== 32'hA5000020 + 32'(cnt)) begin
          n_fail++; $display("FAIL ignore_data idx=%0d got %h want %h", cnt, rd_data, 32'hA5000020 + 32'(cnt));
        end
        cnt++;
      end
      n_checks++; if (done !== (k == 5)) begin n_fail++; $display("FAIL ignore_done k=%0d got %b want %b", k, done, (k == 5)); end
      if (done === 1'b1) ndone++;
      tick();
    end
    n_checks++; if ((cnt != 3) || (ndone != 1) || (busy !== 1'b0)) begin
      n_fail++; $display("FAIL ignore_summary got words=%0d dones=%0d busy=%b want 3 1 0", cnt, ndone, busy);
    end
  endtask

  task automatic test_reset_midburst();
    int acc = 0;
    int ndone = 0;
    rd_ready = 1'b1;
    issue_start(8'h40, 9'd8);
    for (int k = 0; k < 20 && acc < 2; k++) begin
      @(negedge clk);
      if ((rd_valid === 1'b1) && (rd_ready === 1'b1)) acc++;
      tick();
    end
    n_checks++; if (acc != 2) begin n_fail++; $display("FAIL rstmid_pre_accept got %0d want 2", acc); end
    rst = 1'b1;
    #1;
    n_checks++;
    if ((busy !== 1'b0) || (done !== 1'b0) || (rd_valid !== 1'b0) || (mem_addr_in !== 8'h00) ||
        (rd_data !== 32'h0) || (mem_w !== 1'b0)) begin
      n_fail++; $display("FAIL rstmid_outputs got busy=%b done=%b v=%b addr=%h data=%h w=%b want all 0",
                         busy, done, rd_valid, mem_addr_in, rd_data, mem_w);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if ((done !== 1'b0) || (rd_valid !== 1'b0)) begin
        n_fail++; $display("FAIL rstmid_quiet k=%0d got done=%b v=%b want 0 0", k, done, rd_valid);
      end
      tick();
    end
    acc = 0;
    issue_start(8'h50, 9'd3);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if ((rd_valid === 1'b1) && (rd_ready === 1'b1)) begin
        n_checks++;
        if (rd_data !== 32'hA5000050 + 32'(acc)) begin
          n_fail++; $display("FAIL rstmid_data idx=%0d got %h want %h", acc, rd_data, 32'hA5000050 + 32'(acc));
        end
        acc++;
      end
      if (done === 1'b1) ndone++;
      tick();
    end
    n_checks++; if ((acc != 3) || (ndone != 1) || (busy !== 1'b0)) begin
      n_fail++; $display("FAIL rstmid_restart got words=%0d dones=%0d busy=%b want 3 1 0", acc, ndone, busy);
    end
  endtask

`ifdef NV_MEM_RD_CHECKSUM_EN
  task automatic test_checksum();
    int ndone = 0;
    mem[8'h60] = 32'h1;
    mem[8'h61] = 32'h2;
    mem[8'h62] = 32'h4;
    mem[8'h63] = 32'h8;
    rd_ready = 1'b1;
    issue_start(8'h60, 9'd4);
    @(negedge clk);
    n_checks++; if (rd_checksum !== 32'h0) begin n_fail++; $display("FAIL csum_clear got %h want 0", rd_checksum); end
    tick();
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        n_checks++; if (rd_checksum !== 32'h0000000F) begin n_fail++; $display("FAIL csum_done got %h want 0000000f", rd_checksum); end
      end
      tick();
    end
    n_checks++; if ((ndone != 1) || (rd_checksum !== 32'h0000000F)) begin
      n_fail++; $display("FAIL csum_hold got dones=%0d csum=%h want 1 0000000f", ndone, rd_checksum);
    end
    issue_start(8'h10, 9'd1);
    @(negedge clk);
    n_checks++; if (rd_checksum !== 32'h0) begin n_fail++; $display("FAIL csum_restart got %h want 0", rd_checksum); end
    repeat (6) tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 + 32'(i);
    test_reset();
    test_basic();
    tick();
    test_wrap();
    tick();
    test_backpressure();
    tick();
    test_zero_len_and_ignore();
    tick();
    test_reset_midburst();
    tick();
`ifdef NV_MEM_RD_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_mem_reader.md
# nv_mem_reader

Burst read initiator for the on-chip non-volatile key/config memory. On a `start` request it issues a run of consecutive word reads to the memory's one-port interface and streams the returned words downstream on a valid/ready interface. Downstream stalls are absorbed by a 2-entry buffer without losing data. It sits between the memory and the bitstream decryption/configuration logic, which consumes key and configuration words.

## Interface
Parameters:
- `DATA_WIDTH`, 32, memory word width
- `ADDR_WIDTH`, 8, memory address width (depth 2^ADDR_WIDTH)
- `LEN_WIDTH`, ADDR_WIDTH+1, burst length field width (max burst 2^ADDR_WIDTH words)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `start`  in  1  burst request, sampled when idle
- `start_addr`  in  ADDR_WIDTH  first word address
- `length`  in  LEN_WIDTH  number of words to read
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse at burst completion
- `mem_w`  out  1  memory write enable, tied low (read-only initiator)
- `mem_addr_in`  out  ADDR_WIDTH  memory address
- `mem_data_out`  in  DATA_WIDTH  memory read data, registered by the memory one edge after the address
- `rd_data`  out  DATA_WIDTH  streamed word
- `rd_valid`  out  1  `rd_data` valid
- `rd_ready`  in  1  downstream accepts the word
- `rd_checksum`  out  DATA_WIDTH  running XOR of accepted words (only with `NV_MEM_RD_CHECKSUM_EN`)

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: if `start`=1, latch `start_addr` into the address counter and `length` into the issue and accept counters. Go to READ, or to DRAIN if `length`=0. Set `busy`=1.
- READ: issue one read per cycle while issue count > 0 and (buffer occupancy + in-flight reads) < 2. Issuing means driving `mem_addr_in` with the address counter and setting the in-flight flag. The address counter then increments modulo 2^ADDR_WIDTH, so it wraps from 0xFF to 0x00. The issue counter decrements on each issue. When the issue count reaches 0, go to DRAIN.
- In-flight flag set in cycle t: `mem_data_out` is written into the buffer at the end of cycle t+1.
- Buffer: 2-entry FIFO. `rd_valid` = not empty; `rd_data` = head entry. A handshake (`rd_valid` & `rd_ready`) pops the head and decrements the accept counter. A push and a pop in the same cycle are legal.
- DRAIN: wait until the accept counter is 0. Then pulse `done` for one cycle, drop `busy`, and return to IDLE.
- `length`=0: no memory reads and no `rd_valid`. `done` pulses 1 cycle after `start`.
- `start` while `busy`=1 is ignored.
- `mem_w` is constant 0.
- `mem_addr_in` holds its last value while not issuing.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `rd_valid`=0, `mem_w`=0
  - `mem_addr_in`=0, `rd_data`=0, `rd_checksum`=0
  - state IDLE, FIFO empty, in-flight clear
- `rst` asserted mid-burst aborts the burst immediately. The FIFO and in-flight data are discarded and no `done` is produced.
- Latency: with `start` sampled at edge E0:
  - first address is on `mem_addr_in` after E0
  - first word reaches `rd_valid`=1 after E2
- Throughput: 1 word/cycle while `rd_ready`=1. An N-word burst with `rd_ready` held high has `rd_valid` high for N consecutive cycles. `done` is high in the cycle after the last handshake.
- Backpressure: `rd_valid`/`rd_data` stay stable until accepted. While `rd_ready`=0 with 2 words held (buffered + in flight), no further reads are issued.

## Configuration
- `NV_MEM_RD_CHECKSUM_EN` defined:
  - `rd_checksum` port present
  - cleared to 0 when a burst starts
  - XORs in `rd_data` on each handshake
  - equals the XOR of all N words when `done` pulses, and holds until the next start
- Not defined: no `rd_checksum` port and no accumulator logic. All other behaviour is identical.

## Test plan
- Memory preloaded with word[i]=0xA5000000+i. `start_addr`=0x10, `length`=4, `rd_ready`=1 → `rd_valid` from E2 for 4 cycles carrying 0xA5000010..0xA5000013. `done` pulses once, in the cycle after the 4th handshake.
- `start_addr`=0xFE, `length`=4 → addresses issued 0xFE, 0xFF, 0x00, 0x01, and data returned in that order.
- `length`=5, `rd_ready` toggled 1,0,0,1,0,1,… → exactly 5 words, in order, with no duplicates or drops. `rd_data` is stable during stalls, and `mem_addr_in` never runs more than 2 words ahead of acceptance.
- `length`=0 → no `rd_valid`; `done` 1 cycle after `start`. A second `start` issued while `busy`=1 → ignored, and the first burst completes unchanged.
- `rst` asserted after 2 of 8 words accepted → all outputs 0 immediately and no `done`. A new `start` with `length`=3 then completes normally.
- With `NV_MEM_RD_CHECKSUM_EN`, words 0x1, 0x2, 0x4, 0x8 → `rd_checksum`=0x0000000F at `done`. It returns to 0 on the next `start`.
